// File: rtl/fft_pingpong_ctrl.sv
// Front-end frame sequencer for the FFT ping-pong input buffer: frames streaming samples,
// drives the bank-select toggle and runs the start/ack/done handshake with the FFT core.
module fft_pingpong_ctrl #(
    parameter int unsigned LOG2N  = 10,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              bank_q,
    output logic              bank_toggle,
    output logic              wr_en,
    output logic [LOG2N-1:0]  wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              fft_start,
    input  logic              fft_ack,
    input  logic              fft_done,
    output logic [15:0]       frame_count,
    output logic [7:0]        drop_count,
    output logic              overflow,
    input  logic              clear_overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StBusy
    } state_e;

    state_e             state_q, state_d;
    logic [LOG2N-1:0]   cnt_q, cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [LOG2N-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               wr_bank_q, wr_bank_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic [7:0]         drop_count_q, drop_count_d;
    logic               overflow_q, overflow_d;

    logic acc;
    logic last;
    logic swap_ok;
    logic accept;
    logic drop;

    always_comb begin
        acc     = in_valid & enable;
        last    = acc & (cnt_q == {LOG2N{1'b1}});
        // The inactive bank is free when the FFT is idle or releases it this very cycle.
        swap_ok = (state_q == StIdle) | ((state_q == StBusy) & fft_done);
        accept  = last & swap_ok;
        drop    = last & ~swap_ok;
    end

    // Counter wraps on a dropped frame too, so the next frame overwrites the same bank.
    always_comb begin
        cnt_d     = acc ? cnt_q + 1'b1 : cnt_q;
        wr_en_d   = acc;
        wr_addr_d = cnt_q;
        wr_data_d = in_data;
        wr_bank_d = bank_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StStart;
            StStart: if (fft_ack) state_d = StBusy;
            StBusy: begin
                if (accept)        state_d = StStart;
                else if (fft_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        frame_count_d = accept ? frame_count_q + 16'd1 : frame_count_q;

        drop_count_d = drop_count_q;
        overflow_d   = overflow_q;
        // A drop in the same cycle as a clear restarts the count at one.
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)               drop_count_d = 8'd1;
            else if (drop_count_q != 8'hff)   drop_count_d = drop_count_q + 8'd1;
        end else if (clear_overflow) begin
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_bank_q     <= 1'b0;
            frame_count_q <= 16'd0;
            drop_count_q  <= 8'd0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_bank_q     <= wr_bank_d;
            frame_count_q <= frame_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        bank_toggle = accept;
        wr_en       = wr_en_q;
        wr_addr     = wr_addr_q;
        wr_data     = wr_data_q;
        wr_bank     = wr_bank_q;
        rd_bank     = ~bank_q;
        fft_start   = (state_q == StStart);
        frame_count = frame_count_q;
        drop_count  = drop_count_q;
        overflow    = overflow_q;
    end

endmodule

// File: tb/tb_fft_pingpong_ctrl.sv
// Directed bench for fft_pingpong_ctrl with N=8; models the external bank toggle flip-flop.
module tb_fft_pingpong_ctrl;

    localparam int unsigned LOG2N  = 3;
    localparam int unsigned DATA_W = 32;

    logic              clock;
    logic              reset;
    logic              enable;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              bank_q;
    logic              bank_toggle;
    logic              wr_en;
    logic [LOG2N-1:0]  wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_bank;
    logic              rd_bank;
    logic              fft_start;
    logic              fft_ack;
    logic              fft_done;
    logic [15:0]       frame_count;
    logic [7:0]        drop_count;
    logic              overflow;
    logic              clear_overflow;

    int errors = 0;
    int checks = 0;
    logic tog_seen;

    fft_pingpong_ctrl #(
        .LOG2N (LOG2N),
        .DATA_W(DATA_W)
    ) u_dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .bank_q        (bank_q),
        .bank_toggle   (bank_toggle),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_bank       (wr_bank),
        .rd_bank       (rd_bank),
        .fft_start     (fft_start),
        .fft_ack       (fft_ack),
        .fft_done      (fft_done),
        .frame_count   (frame_count),
        .drop_count    (drop_count),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // External toggle flip-flop sharing the reset.
    always_ff @(posedge clock) begin
        if (reset)            bank_q <= 1'b0;
        else if (bank_toggle) bank_q <= ~bank_q;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One accepted sample with full write-port and toggle checks.
    task automatic send_sample(input logic [31:0] d, input int addr, input logic bank,
                               input logic tog);
        in_valid = 1'b1;
        enable   = 1'b1;
        in_data  = d;
        #1;
        check_eq("bank_toggle", bank_toggle, tog);
        tick();
        check_eq("wr_en", wr_en, 1'b1);
        check_eq("wr_addr", wr_addr, addr);
        check_eq("wr_data", wr_data, d);
        check_eq("wr_bank", wr_bank, bank);
    endtask

    task automatic quiet_sample(input logic [31:0] d);
        in_valid = 1'b1;
        enable   = 1'b1;
        in_data  = d;
        #1;
        tog_seen = tog_seen | bank_toggle;
        tick();
    endtask

    initial begin
        reset          = 1'b1;
        enable         = 1'b0;
        in_valid       = 1'b0;
        in_data        = '0;
        fft_ack        = 1'b0;
        fft_done       = 1'b0;
        clear_overflow = 1'b0;
        tog_seen       = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_wr_en", wr_en, 1'b0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_bank", wr_bank, 1'b0);
        check_eq("rst_fft_start", fft_start, 1'b0);
        check_eq("rst_frame_count", frame_count, 0);
        check_eq("rst_drop_count", drop_count, 0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_rd_bank", rd_bank, 1'b1);
        reset = 1'b0;

        // First frame into bank 0
        for (int i = 0; i < 8; i++) send_sample(32'h100 + i, i, 1'b0, i == 7);
        in_valid = 1'b0;
        check_eq("f1_bank_q", bank_q, 1'b1);
        check_eq("f1_fft_start", fft_start, 1'b1);
        check_eq("f1_frame_count", frame_count, 1);
        tick();
        check_eq("f1_wr_en_idle", wr_en, 1'b0);
        check_eq("f1_start_held", fft_start, 1'b1);

        // Ack two cycles after start
        fft_ack = 1'b1;
        tick();
        fft_ack = 1'b0;
        check_eq("ack_fft_start", fft_start, 1'b0);
        check_eq("ack_rd_bank", rd_bank, 1'b0);
        check_eq("ack_bank_q", bank_q, 1'b1);

        // Second frame completes while BUSY: dropped
        for (int i = 0; i < 8; i++) send_sample(32'h200 + i, i, 1'b1, 1'b0);
        check_eq("drop_bank_q", bank_q, 1'b1);
        check_eq("drop_count1", drop_count, 1);
        check_eq("drop_overflow", overflow, 1'b1);
        check_eq("drop_frame_count", frame_count, 1);
        check_eq("drop_fft_start", fft_start, 1'b0);

        // Third frame overwrites bank 1; fft_done coincides with its last sample
        for (int i = 0; i < 7; i++) send_sample(32'h300 + i, i, 1'b1, 1'b0);
        fft_done = 1'b1;
        send_sample(32'h307, 7, 1'b1, 1'b1);
        fft_done = 1'b0;
        in_valid = 1'b0;
        check_eq("b2b_bank_q", bank_q, 1'b0);
        check_eq("b2b_fft_start", fft_start, 1'b1);
        check_eq("b2b_frame_count", frame_count, 2);
        check_eq("b2b_drop_count", drop_count, 1);

        fft_ack = 1'b1;
        tick();
        fft_ack = 1'b0;
        check_eq("ack2_fft_start", fft_start, 1'b0);
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
        // Stray done/ack while IDLE must not start anything
        fft_done = 1'b1;
        fft_ack  = 1'b1;
        tick();
        fft_done = 1'b0;
        fft_ack  = 1'b0;
        check_eq("idle_fft_start", fft_start, 1'b0);

        // Enable gap mid-frame at cnt=4
        for (int i = 0; i < 4; i++) send_sample(32'h400 + i, i, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            enable   = 1'b0;
            in_valid = i[0] ? 1'b0 : 1'b1;
            in_data  = 32'hdead;
            tick();
            check_eq("gap_wr_en", wr_en, 1'b0);
        end
        enable   = 1'b1;
        in_valid = 1'b0;
        tick();
        check_eq("gap_idle_wr_en", wr_en, 1'b0);
        for (int i = 4; i < 8; i++) send_sample(32'h400 + i, i, 1'b0, i == 7);
        in_valid = 1'b0;
        check_eq("gap_bank_q", bank_q, 1'b1);
        check_eq("gap_frame_count", frame_count, 3);
        check_eq("gap_fft_start", fft_start, 1'b1);

        // Reset at cnt=5 discards the partial frame
        for (int i = 0; i < 5; i++) send_sample(32'h500 + i, i, 1'b1, 1'b0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h5ff;
        tick();
        reset = 1'b0;
        check_eq("mrst_wr_en", wr_en, 1'b0);
        check_eq("mrst_wr_addr", wr_addr, 0);
        check_eq("mrst_fft_start", fft_start, 1'b0);
        check_eq("mrst_frame_count", frame_count, 0);
        check_eq("mrst_drop_count", drop_count, 0);
        check_eq("mrst_overflow", overflow, 1'b0);
        check_eq("mrst_bank_q", bank_q, 1'b0);
        send_sample(32'h600, 0, 1'b0, 1'b0);

        // Complete the frame, then never ack so every following frame drops
        for (int i = 1; i < 8; i++) send_sample(32'h600 + i, i, 1'b0, i == 7);
        check_eq("sat_frame_count0", frame_count, 1);
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 8; i++) quiet_sample(f * 8 + i);
            if (f == 0)   check_eq("sat_drop_first", drop_count, 1);
            if (f == 254) check_eq("sat_drop_255", drop_count, 255);
        end
        check_eq("sat_drop_held", drop_count, 255);
        check_eq("sat_overflow", overflow, 1'b1);
        check_eq("sat_no_toggle", tog_seen, 1'b0);
        check_eq("sat_frame_count", frame_count, 1);
        check_eq("sat_bank_q", bank_q, 1'b1);

        // Clear in the same cycle as a drop: drop wins
        for (int i = 0; i < 7; i++) quiet_sample(32'h700 + i);
        clear_overflow = 1'b1;
        quiet_sample(32'h707);
        in_valid = 1'b0;
        check_eq("clr_drop_overflow", overflow, 1'b1);
        check_eq("clr_drop_count", drop_count, 1);
        tick();
        clear_overflow = 1'b0;
        check_eq("clr_overflow", overflow, 1'b0);
        check_eq("clr_drop_count0", drop_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
